// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble sequencer for the 5-stage pipeline registers and PC.
// Optional perf counters enabled by macro HAZARD_PERF_CNT_EN. Rev 1.0
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int REG_W          = 5,
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_cycles
`endif
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam bit         MULTI_FLUSH = (BRANCH_PENALTY > 1);
  localparam logic [1:0] FLUSH_INIT  = 2'(BRANCH_PENALTY - 1);
  localparam logic [7:0] WAIT_MAX    = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [1:0] flush_cnt;
  logic [7:0] wait_cnt;

  logic       mem_stall;
  logic       lu;
  logic       lu_stall;
  logic [7:0] wait_next;

  assign mem_stall = mem_req && !mem_ready;
  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  // A load-use only stalls when nothing of higher priority owns the cycle.
  assign lu_stall  = !mem_stall && (state == RUN) && !ex_branch_taken && lu;
  assign wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 8'd1;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      pipe_freeze = 1'b1;
    end else if ((state == FLUSH) || ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      flush_cnt   <= 2'd0;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else if (mem_stall) begin
      wait_cnt <= wait_next;
      if (wait_next == WAIT_MAX) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= 8'd0;
      case (state)
        RUN: begin
          if (ex_branch_taken && MULTI_FLUSH) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_INIT;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 2'd1;
          if (flush_cnt == 2'd1) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if ((mem_stall || lu_stall) && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (if_id_flush && (flush_cycles != 32'hFFFF_FFFF)) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`else
  logic unused_lu_stall;
  assign unused_lu_stall = lu_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two instances (BRANCH_PENALTY=2/MEM_TIMEOUT=4 and BRANCH_PENALTY=3/MEM_TIMEOUT=15)
// share stimulus and are compared against a behavioural model each cycle.
`default_nettype none

module tb_pipeline_hazard_ctrl;

  typedef logic [5:0] vec_t;  // {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout}
  typedef struct {
    vec_t a;
    vec_t b;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0;
  logic       ex_branch_taken = 0, mem_req = 0, mem_ready = 0;

  logic pc_we_a, if_id_we_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a, mem_timeout_a;
  logic pc_we_b, if_id_we_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b, mem_timeout_b;

  int   passed = 0;
  int   total = 0;
  int   ncyc = 0;
  exp_t sb[$];

  int   bp[2] = '{2, 3};
  int   mt[2] = '{4, 15};
  int   m_flush[2] = '{0, 0};  // flush cycles still owed after the current one
  int   m_wait[2] = '{0, 0};
  bit   m_tmo[2] = '{0, 0};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .BRANCH_PENALTY(2), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_we(pc_we_a), .if_id_we(if_id_we_a),
    .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a),
    .pipe_freeze(pipe_freeze_a), .mem_timeout(mem_timeout_a)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .BRANCH_PENALTY(3), .MEM_TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_we(pc_we_b), .if_id_we(if_id_we_b),
    .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b),
    .pipe_freeze(pipe_freeze_b), .mem_timeout(mem_timeout_b)
  );

  // Expected outputs for the current inputs; advances the model to the next cycle.
  function automatic vec_t model(int k);
    vec_t o;
    bit   stall;
    bit   hz;
    o = '0;
    if (!rst_n) begin
      m_flush[k] = 0;
      m_wait[k]  = 0;
      m_tmo[k]   = 0;
      return 6'b001100;
    end
    o[0]  = m_tmo[k];
    stall = mem_req && !mem_ready;
    hz    = ex_mem_read && (ex_rt != 0) &&
            ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    if (stall) begin
      o[5:1] = 5'b00001;
      if (m_wait[k] < mt[k]) m_wait[k] = m_wait[k] + 1;
      if (m_wait[k] >= mt[k]) m_tmo[k] = 1;
    end else begin
      m_wait[k] = 0;
      if (m_flush[k] > 0) begin
        o[5:1] = 5'b11110;
        m_flush[k] = m_flush[k] - 1;
      end else if (ex_branch_taken) begin
        o[5:1] = 5'b11110;
        m_flush[k] = bp[k] - 1;
      end else if (hz) begin
        o[5:1] = 5'b00010;
      end else begin
        o[5:1] = 5'b11000;
      end
    end
    return o;
  endfunction

  task automatic cyc(input bit rn, input bit br, input bit rq, input bit rd, input bit mr,
                     input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                     input bit urs, input bit urt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; ex_branch_taken = br; mem_req = rq; mem_ready = rd;
    ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt;
    e.a   = model(0);
    e.b   = model(1);
    e.cyc = ncyc;
    ncyc  = ncyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    vec_t ga, gb;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ga = {pc_we_a, if_id_we_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a, mem_timeout_a};
        gb = {pc_we_b, if_id_we_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b, mem_timeout_b};
        total = total + 1;
        if (ga === e.a) passed = passed + 1;
        else $display("FAIL dut_a cyc=%0d got=%b exp=%b", e.cyc, ga, e.a);
        total = total + 1;
        if (gb === e.b) passed = passed + 1;
        else $display("FAIL dut_b cyc=%0d got=%b exp=%b", e.cyc, gb, e.b);
      end
    end
  end

  initial begin
    int guard;
    // reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use via rs, then release
    cyc(1, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    idle(1);
    // load-use via rt; matching rs that is not read must not stall
    cyc(1, 0, 0, 0, 1, 7, 0, 7, 0, 1);
    cyc(1, 0, 0, 0, 1, 7, 7, 0, 0, 0);
    // register zero never stalls
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    // branch, second branch during flush is ignored
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // memory wait of 3 cycles with a branch pending, resolved on the ready cycle
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 5, 5, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // timeout on dut_a, sticky, cleared by reset
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // reset during the second flush cycle
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 0,
          $urandom_range(0, 1) == 0);
    end
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard = guard + 1;
    end
    if (sb.size() > 0) begin
      total = total + 1;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
